// File: rtl/dsi_pkt_pkg.sv
// Shared DSI packet definitions: data types, header ECC and payload CRC constants.
package dsi_pkt_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_CHECK,
    ST_PAYLOAD,
    ST_CRC0,
    ST_CRC1
  } state_t;

  localparam logic [5:0] DT_NULL        = 6'h09;
  localparam logic [5:0] DT_BLANK       = 6'h19;
  localparam logic [5:0] DT_GEN_LONG_WR = 6'h29;
  localparam logic [5:0] DT_DCS_LONG_WR = 6'h39;
  localparam logic [5:0] DT_PPS_RGB565  = 6'h0E;
  localparam logic [5:0] DT_PPS_RGB666  = 6'h1E;
  localparam logic [5:0] DT_PPS_RGB666L = 6'h2E;
  localparam logic [5:0] DT_PPS_RGB888  = 6'h3E;

  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  // Per-parity-bit data masks of the 24-bit header Hamming code, P5 leftmost.
  localparam logic [5:0][23:0] ECC_MASK = {
    24'hEFFC00, 24'hDF03F0, 24'hB8E38E, 24'h749A6D, 24'hF2555B, 24'hF12CB7
  };

  typedef logic [23:0][5:0] col_table_t;

  function automatic logic is_long_dt(input logic [5:0] dt);
    case (dt)
      DT_NULL, DT_BLANK, DT_GEN_LONG_WR, DT_DCS_LONG_WR,
      DT_PPS_RGB565, DT_PPS_RGB666, DT_PPS_RGB666L, DT_PPS_RGB888,
      6'h0C, 6'h1C, 6'h2C, 6'h3C, 6'h0D, 6'h1D, 6'h2D, 6'h3D, 6'h1A:
        return 1'b1;
      default:
        return 1'b0;
    endcase
  endfunction

  function automatic logic [5:0] ecc_of(input logic [23:0] d);
    logic [5:0] p;
    for (int unsigned k = 0; k < 6; k++) p[3'(k)] = ^(d & ECC_MASK[3'(k)]);
    return p;
  endfunction

  // Syndrome produced by a single flipped data bit i is simply the ECC of that one-hot word.
  function automatic col_table_t ecc_col_table();
    col_table_t t;
    for (int unsigned i = 0; i < 24; i++) t[5'(i)] = ecc_of(24'd1 << i);
    return t;
  endfunction

  localparam col_table_t ECC_COL = ecc_col_table();

endpackage

// File: rtl/byte_crc.sv
// One-byte update of the DSI payload CRC-16 (x^16+x^12+x^5+1), bits taken LSB first.
module byte_crc (
  input  logic [15:0] crc_in,
  input  logic [7:0]  data,
  output logic [15:0] crc_out
);

  logic [15:0] c;

  always_comb begin
    c = crc_in;
    for (int unsigned i = 0; i < 8; i++) begin
      if (c[0] ^ data[3'(i)]) c = (c >> 1) ^ 16'h8408;
      else                    c = c >> 1;
    end
    crc_out = c;
  end

endmodule

// File: rtl/ecc_calc.sv
// Combinational 6-bit Hamming ECC over a 24-bit DSI packet header.
module ecc_calc
  import dsi_pkt_pkg::*;
(
  input  logic [23:0] data,
  output logic [5:0]  ecc
);

  assign ecc = ecc_of(data);

endmodule

// File: rtl/dsi_packet_checker.sv
// DSI receive packet checker: header ECC correct/detect, payload forwarding, checksum compare.
module dsi_packet_checker
  import dsi_pkt_pkg::*;
#(
  parameter int CRC_EN       = 1,
  parameter int ECC_RSVD_CHK = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic        in_sop,
  input  logic [7:0]  in_data,
  output logic        hdr_valid,
  output logic [7:0]  hdr_data_id,
  output logic [15:0] hdr_word_count,
  output logic        hdr_long,
  output logic        ecc_corrected,
  output logic        ecc_error,
  output logic        pld_valid,
  output logic [7:0]  pld_data,
  output logic        pld_last,
  output logic        crc_valid,
  output logic        crc_ok,
  output logic        pkt_abort,
  output logic        busy
);

  state_t      state_q, state_d, phase;
  logic [1:0]  cnt_q, cnt_d;
  logic [23:0] hdr_q, hdr_d, hdr_fix;
  logic [5:0]  syn_q, syn_d, ecc_rx_calc;
  logic        rsvd_q, rsvd_d;
  logic [15:0] rem_q, rem_d, rem_cur;
  logic [15:0] crc_q, crc_d, crc_next;
  logic [7:0]  crc_lo_q, crc_lo_d;
  logic        fix_corr, fix_err;
  logic        hdr_valid_d, ecc_corrected_d, ecc_error_d, pkt_abort_d;
  logic        pld_valid_d, pld_last_d, crc_valid_d, crc_ok_d;
  logic [7:0]  pld_data_d;

  ecc_calc u_ecc (
    .data (hdr_q),
    .ecc  (ecc_rx_calc)
  );

  byte_crc u_crc (
    .crc_in  (crc_q),
    .data    (in_data),
    .crc_out (crc_next)
  );

  assign hdr_data_id    = hdr_q[7:0];
  assign hdr_word_count = hdr_q[23:8];
  assign hdr_long       = is_long_dt(hdr_q[5:0]);
  assign busy           = (state_q != ST_IDLE);

  always_comb begin
    hdr_fix  = hdr_q;
    fix_corr = 1'b0;
    fix_err  = 1'b0;
    if (syn_q != '0) begin
      if ($onehot(syn_q)) begin
        fix_corr = 1'b1;
      end else begin
        fix_err = 1'b1;
        for (int unsigned i = 0; i < 24; i++) begin
          if (syn_q == ECC_COL[5'(i)]) begin
            hdr_fix[5'(i)] = ~hdr_q[5'(i)];
            fix_corr       = 1'b1;
            fix_err        = 1'b0;
          end
        end
      end
    end
    if ((ECC_RSVD_CHK != 0) && rsvd_q) fix_err = 1'b1;
  end

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    hdr_d           = hdr_q;
    syn_d           = syn_q;
    rsvd_d          = rsvd_q;
    crc_d           = crc_q;
    crc_lo_d        = crc_lo_q;
    pld_data_d      = pld_data;
    hdr_valid_d     = 1'b0;
    ecc_corrected_d = 1'b0;
    ecc_error_d     = 1'b0;
    pkt_abort_d     = 1'b0;
    pld_valid_d     = 1'b0;
    pld_last_d      = 1'b0;
    crc_valid_d     = 1'b0;
    crc_ok_d        = 1'b0;
    phase           = state_q;
    rem_cur         = rem_q;

    // CHECK resolves into the state that handles a byte arriving in that same cycle,
    // so a back-to-back stream loses nothing across the decode cycle.
    if (state_q == ST_CHECK) begin
      if (fix_err) begin
        ecc_error_d = 1'b1;
        phase       = ST_IDLE;
      end else begin
        hdr_valid_d     = 1'b1;
        ecc_corrected_d = fix_corr;
        hdr_d           = hdr_fix;
        if (!is_long_dt(hdr_fix[5:0])) begin
          phase = ST_IDLE;
        end else if (hdr_fix[23:8] == '0) begin
          phase = ST_CRC0;
        end else begin
          phase   = ST_PAYLOAD;
          rem_cur = hdr_fix[23:8];
        end
      end
    end
    state_d = phase;
    rem_d   = rem_cur;

    if (in_valid && in_sop) begin
      pkt_abort_d     = (state_q != ST_IDLE);
      hdr_valid_d     = 1'b0;
      ecc_corrected_d = 1'b0;
      ecc_error_d     = 1'b0;
      hdr_d           = {16'h0000, in_data};
      cnt_d           = 2'd1;
      crc_d           = CRC_INIT;
      state_d         = ST_HDR;
    end else if (in_valid) begin
      case (phase)
        ST_HDR: begin
          case (cnt_q)
            2'd1:    hdr_d[15:8]  = in_data;
            2'd2:    hdr_d[23:16] = in_data;
            default: begin
              syn_d   = ecc_rx_calc ^ in_data[5:0];
              rsvd_d  = |in_data[7:6];
              state_d = ST_CHECK;
            end
          endcase
          if (cnt_q != 2'd3) cnt_d = cnt_q + 2'd1;
        end
        ST_PAYLOAD: begin
          pld_valid_d = 1'b1;
          pld_data_d  = in_data;
          crc_d       = crc_next;
          rem_d       = rem_cur - 16'd1;
          if (rem_cur == 16'd1) begin
            pld_last_d = 1'b1;
            state_d    = ST_CRC0;
          end
        end
        ST_CRC0: begin
          crc_lo_d = in_data;
          state_d  = ST_CRC1;
        end
        ST_CRC1: begin
          crc_valid_d = 1'b1;
          crc_ok_d    = ({in_data, crc_lo_q} == crc_q) || (CRC_EN == 0);
          state_d     = ST_IDLE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      hdr_q         <= '0;
      syn_q         <= '0;
      rsvd_q        <= 1'b0;
      rem_q         <= '0;
      crc_q         <= CRC_INIT;
      crc_lo_q      <= '0;
      hdr_valid     <= 1'b0;
      ecc_corrected <= 1'b0;
      ecc_error     <= 1'b0;
      pkt_abort     <= 1'b0;
      pld_valid     <= 1'b0;
      pld_data      <= '0;
      pld_last      <= 1'b0;
      crc_valid     <= 1'b0;
      crc_ok        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      hdr_q         <= hdr_d;
      syn_q         <= syn_d;
      rsvd_q        <= rsvd_d;
      rem_q         <= rem_d;
      crc_q         <= crc_d;
      crc_lo_q      <= crc_lo_d;
      hdr_valid     <= hdr_valid_d;
      ecc_corrected <= ecc_corrected_d;
      ecc_error     <= ecc_error_d;
      pkt_abort     <= pkt_abort_d;
      pld_valid     <= pld_valid_d;
      pld_data      <= pld_data_d;
      pld_last      <= pld_last_d;
      crc_valid     <= crc_valid_d;
      crc_ok        <= crc_ok_d;
    end
  end

endmodule

// File: tb/tb_dsi_packet_checker.sv
// Scoreboard bench for dsi_packet_checker: directed packets, expected events queued at issue time.
module tb_dsi_packet_checker;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_sop = 1'b0;
  logic [7:0]  in_data = '0;

  logic        hdr_valid, hdr_long, ecc_corrected, ecc_error;
  logic [7:0]  hdr_data_id, pld_data;
  logic [15:0] hdr_word_count;
  logic        pld_valid, pld_last, crc_valid, crc_ok, pkt_abort, busy;

  logic        u2_hdr_valid, u2_hdr_long, u2_ecc_corrected, u2_ecc_error;
  logic [7:0]  u2_hdr_data_id, u2_pld_data;
  logic [15:0] u2_hdr_word_count;
  logic        u2_pld_valid, u2_pld_last, u2_crc_valid, u2_crc_ok, u2_pkt_abort, u2_busy;

  dsi_packet_checker #(.CRC_EN(1), .ECC_RSVD_CHK(0)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_sop(in_sop), .in_data(in_data),
    .hdr_valid(hdr_valid), .hdr_data_id(hdr_data_id), .hdr_word_count(hdr_word_count),
    .hdr_long(hdr_long), .ecc_corrected(ecc_corrected), .ecc_error(ecc_error),
    .pld_valid(pld_valid), .pld_data(pld_data), .pld_last(pld_last),
    .crc_valid(crc_valid), .crc_ok(crc_ok), .pkt_abort(pkt_abort), .busy(busy)
  );

  dsi_packet_checker #(.CRC_EN(0), .ECC_RSVD_CHK(0)) u_dut_nocrc (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_sop(in_sop), .in_data(in_data),
    .hdr_valid(u2_hdr_valid), .hdr_data_id(u2_hdr_data_id), .hdr_word_count(u2_hdr_word_count),
    .hdr_long(u2_hdr_long), .ecc_corrected(u2_ecc_corrected), .ecc_error(u2_ecc_error),
    .pld_valid(u2_pld_valid), .pld_data(u2_pld_data), .pld_last(u2_pld_last),
    .crc_valid(u2_crc_valid), .crc_ok(u2_crc_ok), .pkt_abort(u2_pkt_abort), .busy(u2_busy)
  );

  always #5 clk = ~clk;

  typedef enum int {K_ABORT, K_ERR, K_HDR, K_PLD, K_CRC} kind_e;
  typedef struct {
    kind_e       kind;
    logic [7:0]  a;
    logic [15:0] b;
    logic        c;
    logic        d;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail = 0;
  int   exp_crc2 = 0;
  int   got_crc2 = 0;
  bit   gap = 1'b0;

  task automatic expect_evt(input kind_e k, input logic [7:0] a, input logic [15:0] b,
                            input logic c, input logic d);
    exp_t e;
    e.kind = k; e.a = a; e.b = b; e.c = c; e.d = d;
    sb.push_back(e);
    if (k == K_CRC) exp_crc2++;
  endtask

  task automatic observe(input kind_e k, input logic [7:0] a, input logic [15:0] b,
                         input logic c, input logic d);
    exp_t e;
    n_tests++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_%s: got a=%0h b=%0h c=%0b d=%0b, required no event",
               k.name(), a, b, c, d);
    end else begin
      e = sb.pop_front();
      if (e.kind != k || e.a !== a || e.b !== b || e.c !== c || e.d !== d) begin
        n_fail++;
        $display("FAIL event_%s: got %s a=%0h b=%0h c=%0b d=%0b, required %s a=%0h b=%0h c=%0b d=%0b",
                 e.kind.name(), k.name(), a, b, c, d, e.kind.name(), e.a, e.b, e.c, e.d);
      end
    end
  endtask

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", nm, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (pkt_abort) observe(K_ABORT, 8'h00, 16'h0000, 1'b0, 1'b0);
      if (ecc_error) observe(K_ERR, 8'h00, 16'h0000, 1'b0, 1'b0);
      if (hdr_valid) observe(K_HDR, hdr_data_id, hdr_word_count, hdr_long, ecc_corrected);
      if (pld_valid) observe(K_PLD, pld_data, 16'h0000, pld_last, 1'b0);
      if (crc_valid) observe(K_CRC, 8'h00, 16'h0000, crc_ok, 1'b0);
      if (u2_crc_valid) begin
        got_crc2++;
        n_tests++;
        if (u2_crc_ok !== 1'b1) begin
          n_fail++;
          $display("FAIL nocrc_crc_ok: got %0b, required 1", u2_crc_ok);
        end
      end
    end
  end

  // Independent CRC model: non-reflected 0x1021 on a bit-reversed register.
  function automatic logic [15:0] rev16(input logic [15:0] v);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[i] = v[15-i];
    return r;
  endfunction

  function automatic logic [15:0] crc_ref(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] n;
    logic        fb;
    n = rev16(c);
    for (int i = 0; i < 8; i++) begin
      fb = n[15] ^ d[i];
      n  = {n[14:0], 1'b0};
      if (fb) n = n ^ 16'h1021;
    end
    return rev16(n);
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] d, input logic sop);
    in_valid = 1'b1;
    in_sop   = sop;
    in_data  = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sop   = 1'b0;
    in_data  = 8'h00;
    if (gap) idle(1);
  endtask

  task automatic sc1();
    expect_evt(K_HDR, 8'h39, 16'h0000, 1'b1, 1'b0);
    expect_evt(K_CRC, 8'h00, 16'h0000, 1'b1, 1'b0);
    send(8'h39, 1'b1); send(8'h00, 1'b0); send(8'h00, 1'b0); send(8'h0F, 1'b0);
    send(8'hFF, 1'b0); send(8'hFF, 1'b0);
  endtask

  task automatic sc2(input logic bad);
    logic [15:0] c;
    c = crc_ref(crc_ref(16'hFFFF, 8'hA5), 8'h3C);
    expect_evt(K_HDR, 8'h39, 16'h0002, 1'b1, 1'b1);
    expect_evt(K_PLD, 8'hA5, 16'h0000, 1'b0, 1'b0);
    expect_evt(K_PLD, 8'h3C, 16'h0000, 1'b1, 1'b0);
    expect_evt(K_CRC, 8'h00, 16'h0000, !bad, 1'b0);
    send(8'h39, 1'b1); send(8'h00, 1'b0); send(8'h00, 1'b0); send(8'h13, 1'b0);
    send(8'hA5, 1'b0); send(8'h3C, 1'b0);
    send(c[7:0] ^ {7'd0, bad}, 1'b0); send(c[15:8], 1'b0);
  endtask

  function automatic logic [63:0] all_outs();
    return {22'd0, hdr_valid, hdr_data_id, hdr_word_count, hdr_long, ecc_corrected, ecc_error,
            pld_valid, pld_data, pld_last, crc_valid, crc_ok, pkt_abort, busy};
  endfunction

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", all_outs(), 64'd0);
    reset = 1'b0;
    idle(2);

    sc1();
    idle(3);

    // Short packet DI=0x05
    expect_evt(K_HDR, 8'h05, 16'h0000, 1'b0, 1'b0);
    send(8'h05, 1'b1); send(8'h00, 1'b0); send(8'h00, 1'b0); send(8'h0A, 1'b0);
    idle(3);

    // ECC-bit error (P5 flipped): corrected, data unchanged
    expect_evt(K_HDR, 8'h39, 16'h0000, 1'b1, 1'b1);
    expect_evt(K_CRC, 8'h00, 16'h0000, 1'b1, 1'b0);
    send(8'h39, 1'b1); send(8'h00, 1'b0); send(8'h00, 1'b0); send(8'h2F, 1'b0);
    send(8'hFF, 1'b0); send(8'hFF, 1'b0);
    idle(3);

    sc2(1'b0);
    idle(3);

    // Double-bit header error, trailing bytes without sop are dropped
    expect_evt(K_ERR, 8'h00, 16'h0000, 1'b0, 1'b0);
    send(8'h3A, 1'b1); send(8'h02, 1'b0); send(8'h00, 1'b0); send(8'h13, 1'b0);
    send(8'h11, 1'b0); send(8'h22, 1'b0);
    idle(3);
    check("busy_after_ecc_error", {63'd0, busy}, 64'd0);

    sc2(1'b1);
    idle(3);

    // Abort during payload byte 1 of a WC=4 packet
    expect_evt(K_HDR, 8'h39, 16'h0004, 1'b1, 1'b0);
    expect_evt(K_PLD, 8'hA1, 16'h0000, 1'b0, 1'b0);
    expect_evt(K_ABORT, 8'h00, 16'h0000, 1'b0, 1'b0);
    send(8'h39, 1'b1); send(8'h04, 1'b0); send(8'h00, 1'b0); send(8'h2C, 1'b0);
    send(8'hA1, 1'b0);
    sc1();
    idle(3);

    // Abort coinciding with the CHECK cycle
    expect_evt(K_ABORT, 8'h00, 16'h0000, 1'b0, 1'b0);
    send(8'h05, 1'b1); send(8'h00, 1'b0); send(8'h00, 1'b0); send(8'h0A, 1'b0);
    sc1();
    idle(3);

    // Abort in place of the checksum MSB
    expect_evt(K_HDR, 8'h39, 16'h0000, 1'b1, 1'b0);
    expect_evt(K_ABORT, 8'h00, 16'h0000, 1'b0, 1'b0);
    send(8'h39, 1'b1); send(8'h00, 1'b0); send(8'h00, 1'b0); send(8'h0F, 1'b0);
    send(8'hFF, 1'b0);
    sc1();
    idle(3);

    gap = 1'b1;
    sc2(1'b0);
    gap = 1'b0;
    idle(3);

    // Reset mid-payload
    expect_evt(K_HDR, 8'h39, 16'h0002, 1'b1, 1'b1);
    expect_evt(K_PLD, 8'hA5, 16'h0000, 1'b0, 1'b0);
    send(8'h39, 1'b1); send(8'h00, 1'b0); send(8'h00, 1'b0); send(8'h13, 1'b0);
    send(8'hA5, 1'b0); send(8'h3C, 1'b0);
    reset = 1'b1;
    #2;
    check("midpkt_reset_outputs", all_outs(), 64'd0);
    idle(2);
    reset = 1'b0;
    idle(2);
    sc1();
    idle(5);

    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    check("nocrc_crc_count", 64'(got_crc2), 64'(exp_crc2));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dsi_packet_checker.md
Name: dsi_packet_checker

Overview:
- Receive-side counterpart of the DSI packet builder.
- Takes the de-serialised byte stream of one DSI lane-merged packet, checks and corrects the 24-bit header with the 6-bit Hamming ECC, forwards the long-packet payload, and checks the trailing 16-bit checksum (CRC-16, poly x^16+x^12+x^5+1, init 0xFFFF).
- Sits between the lane merger and the command/read-response decoder.

Parameters:
- CRC_EN, 1: 0 disables the checksum compare; crc_ok is then always 1 at crc_valid.
- ECC_RSVD_CHK, 0: 1 means a nonzero value in received ECC bits [7:6] raises ecc_error.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous reset, active-high
- in_valid  in  1  in_data carries a byte this cycle; no backpressure
- in_sop  in  1  qualifies the first header byte (DI); valid only with in_valid
- in_data  in  8  stream byte
- hdr_valid  out  1  one-cycle pulse: header fields valid
- hdr_data_id  out  8  DI, after correction
- hdr_word_count  out  16  WC {byte2,byte1}, after correction
- hdr_long  out  1  packet is a long packet
- ecc_corrected  out  1  a single-bit error was corrected, in a data or ECC bit (with hdr_valid)
- ecc_error  out  1  one-cycle pulse: uncorrectable header
- pld_valid  out  1  payload byte strobe
- pld_data  out  8  payload byte
- pld_last  out  1  last payload byte (with pld_valid)
- crc_valid  out  1  one-cycle pulse: checksum compared
- crc_ok  out  1  compare result (with crc_valid)
- pkt_abort  out  1  one-cycle pulse: in_sop arrived before the current packet completed
- busy  out  1  state != IDLE

Behaviour:
- Reset: all outputs 0, state IDLE, byte counter 0, crc register 0xFFFF. Reset mid-packet discards the packet with no pulses.
- Byte ordering: header data[23:0] = {WC_MSB, WC_LSB, DI}, ECC is byte 3. Checksum is sent LSB first.
- States:
  - IDLE: bytes without in_sop are ignored. in_valid&in_sop -> HDR, store DI, count=1.
  - HDR: collect bytes 1..3. On byte 3, syndrome = ecc_calc(data) ^ rx_ecc[5:0].
  - CHECK (one cycle): evaluate the syndrome.
    - 0: OK.
    - Equals the column of data bit i: flip bit i, ecc_corrected=1.
    - Power of two: ECC-bit error, data unchanged, ecc_corrected=1.
    - Otherwise: ecc_error pulse, no hdr_valid, -> IDLE.
    - On success: hdr_valid pulse. Short packet -> IDLE. Long with WC>0 -> PAYLOAD. Long with WC=0 -> CRC0.
  - PAYLOAD: each byte goes out on pld_valid the next cycle, is folded into the CRC and decrements the remaining count. The byte that brings remaining to 0 carries pld_last and moves to CRC0.
  - CRC0/CRC1: capture checksum LSB/MSB. After the MSB, the next cycle pulses crc_valid with crc_ok = (rx == crc) | ~CRC_EN, then -> IDLE.
- Long packet: DT = DI[5:0] is in the long set {0x09,0x19,0x29,0x39,0x0C,0x1C,0x2C,0x3C,0x0D,0x1D,0x2D,0x3D,0x0E,0x1E,0x2E,0x3E,0x1A}. All other DTs are short.
- Latency:
  - hdr_valid: 2 cycles after the ECC byte is accepted.
  - pld_*: 1 cycle after the byte.
  - crc_valid: 1 cycle after the checksum MSB.
- Gaps: in_valid low holds state and counters in every state; there is no timeout.
- in_sop in any state other than IDLE: pkt_abort pulses, the current packet is discarded (no crc_valid or hdr_valid for it), the byte is taken as a new DI, -> HDR.
  - If this coincides with the CHECK cycle, the abort wins.
- in_sop during the CRC1 byte is still an abort.
- WC=0xFFFF: the 16-bit counter must not wrap early; 65535 payload bytes.
- CRC register resets to 0xFFFF when a new header starts.

Decomposition:
- Package dsi_pkt_pkg holds:
  - DT constants and the is_long_dt function.
  - The 24-entry ECC syndrome column table, derived from ecc_calc.
  - CRC_INIT = 16'hFFFF.
- Reuse the existing ecc_calc and byte_crc modules as instances; no new sub-module.

Test Plan:
1. Long, WC=0: bytes 39 00 00 0F FF FF (sop on first) -> hdr_valid, id=0x39, wc=0, hdr_long=1, ecc_corrected=0; no pld_valid; crc_valid, crc_ok=1.
2. Single-bit header correction: 39 00 00 13 (true WC 0x0002, ECC 0x13, bit 9 flipped) -> syndrome 0x1C, wc=0x0002, ecc_corrected=1. Then 2 payload bytes and a golden byte_crc checksum -> 2 pld_valid, second with pld_last, crc_ok=1.
3. Double-bit error: 3A 02 00 13 (bits 0,1 flipped) -> syndrome 0x0C, ecc_error pulse, no hdr_valid, busy=0 after; following bytes without sop are ignored.
4. Bad checksum: scenario 2 with checksum LSB ^0x01 -> crc_valid, crc_ok=0. Repeat with CRC_EN=0 -> crc_ok=1.
5. Abort: in_sop during PAYLOAD byte 1 of a WC=4 packet -> pkt_abort pulse, no crc_valid for the old packet, new header decoded normally.
6. Gaps and reset: in_valid toggled 1/0 through scenario 2 -> identical outputs. reset asserted mid-PAYLOAD -> outputs 0, then a clean decode of scenario 1.
